// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and decode helper for the 7-segment scan display
//
// Purpose: segment patterns (active-high, bit0=a .. bit6=g, bit7=dp), the
// display page enum, digit-position constants and the BCD-to-segment decoder.
// Ports: none (package).

package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [7:0] SEG_DP    = 8'h80;

    typedef enum logic {
        PAGE_HHMM = 1'b0,
        PAGE_MMSS = 1'b1
    } page_e;

    // Digit positions as seen by the scan index (0 = rightmost digit).
    // The colon dot lives on the digit left of the middle gap.
    localparam logic [1:0] POS_COLON = 2'd2;
    localparam logic [1:0] POS_LEFT  = 2'd3;

    // Non-decimal nibbles decode to an all-off digit rather than hex glyphs.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchronizer plus stable-count debouncer
//
// Purpose: turns a raw asynchronous push button into a clean level and a
// one-cycle rising-edge pulse. The level only changes after DB_CYCLES
// consecutive synchronized samples disagree with it; any agreeing sample
// restarts the count.
// Ports:
//   CLK    in   system clock
//   RESET  in   synchronous active-high reset
//   raw    in   asynchronous button input, active-high
//   level  out  debounced button level
//   rise   out  one-cycle pulse, coincident with the clock edge at which
//               level goes from 0 to 1 (combinational from the flops)

module button_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            // cnt_q counts disagreeing samples already seen; this sample is
            // one more, so the DB_CYCLES-th one flips the level.
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 4-digit multiplexed 7-segment driver for the 24h clock
//
// Purpose: scans four digits of the BCD time (HH:MM or MM:SS page, chosen by
// a debounced button), with a blank slot between digits against ghosting,
// hour-tens leading-zero blanking, a colon dot that toggles on each 1 Hz tick
// and per-frame snapshots of the time so a frame never mixes two times.
// Ports:
//   CLK       in   system clock
//   RESET     in   synchronous active-high reset
//   DIGITS    in   {H10,H1,M10,M1,S10,S1} BCD nibbles, H10 in [23:20]
//   TICK      in   one-cycle 1 Hz pulse
//   BTN_PAGE  in   raw page button, active-high
//   LED       out  segments a..g in bits 0..6, dp in bit 7, active-high
//   SA        out  one-hot digit strobe, SA[0] = rightmost digit

module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 25000,
    parameter int DB_CYCLES = 50000,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:0] DIGITS,
    input  logic        TICK,
    input  logic        BTN_PAGE,
    output logic [7:0]  LED,
    output logic [3:0]  SA
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q,   idx_d;
    logic          first_q, first_d;
    logic [23:0]   snap_q,  snap_d;
    page_e         page_q,  page_d;
    page_e         page_shown_q, page_shown_d;
    logic          blink_q, blink_d;

    logic          strobe;
    logic          snap_take;
    logic          btn_rise;
    logic          btn_level_unused;

    // The page button only needs its press edge here; the steady level is
    // kept on the sub-module for other users of the debouncer.
    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_page (
        .CLK   (CLK),
        .RESET (RESET),
        .raw   (BTN_PAGE),
        .level (btn_level_unused),
        .rise  (btn_rise)
    );

    // ------------------------------------------------------------------
    // Scan timing, snapshot, page and colon state
    // ------------------------------------------------------------------
    assign strobe = (presc_q == PW'(SCAN_DIV - 1));

    // A new frame's data is captured in the very first cycle out of reset
    // and at the strobe that moves the scan from the leftmost digit back to
    // digit 0, so the whole next frame is drawn from one sample.
    assign snap_take = first_q | (strobe & (idx_q == POS_LEFT));

    always_comb begin
        presc_d      = strobe ? '0 : presc_q + PW'(1);
        idx_d        = strobe ? idx_q + 2'd1 : idx_q;
        first_d      = 1'b0;
        snap_d       = snap_take ? DIGITS : snap_q;
        // page_shown takes the pre-edge page, so a press landing on a
        // snapshot edge becomes visible one frame later.
        page_shown_d = snap_take ? page_q : page_shown_q;
        page_d       = page_q;
        if (btn_rise) begin
            page_d = (page_q == PAGE_HHMM) ? PAGE_MMSS : PAGE_HHMM;
        end
        blink_d      = blink_q ^ TICK;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            first_q      <= 1'b1;
            snap_q       <= 24'h000000;
            page_q       <= PAGE_HHMM;
            page_shown_q <= PAGE_HHMM;
            blink_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            snap_q       <= snap_d;
            page_q       <= page_d;
            page_shown_q <= page_shown_d;
            blink_q      <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and segment drive
    // ------------------------------------------------------------------
    logic [15:0] window;
    logic [3:0]  nibble;
    logic [7:0]  seg;
    logic        dp;
    logic        display_on;

    always_comb begin
        // The page picks which four of the six nibbles are visible; within
        // that window idx addresses nibbles from the right.
        window = (page_shown_q == PAGE_MMSS) ? snap_q[15:0] : snap_q[23:8];
        nibble = window[{idx_q, 2'b00} +: 4];
        seg    = bcd_to_seg(nibble);
        if (LZ_BLANK && (page_shown_q == PAGE_HHMM) &&
            (idx_q == POS_LEFT) && (nibble == 4'd0)) begin
            seg = SEG_BLANK;
        end
        dp = (idx_q == POS_COLON) & blink_q;
    end

    // Prescaler value 0 is exactly the cycle after a strobe (and the first
    // cycle after reset), which is the anti-ghost blank slot.
    assign display_on = (presc_q != '0);

    always_comb begin
        LED = SEG_BLANK;
        SA  = 4'b0000;
        if (display_on) begin
            LED = seg | (dp ? SEG_DP : SEG_BLANK);
            SA  = 4'b0001 << idx_q;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display
`timescale 1ns/1ps

module tb_seg7_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int DB_CYCLES = 8;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits;
    logic        tick;
    logic        btn;
    logic [7:0]  led, led_nolz;
    logic [3:0]  sa, sa_nolz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .SCAN_DIV (SCAN_DIV), .DB_CYCLES (DB_CYCLES), .LZ_BLANK (1'b1)
    ) dut (
        .CLK (clk), .RESET (rst), .DIGITS (digits), .TICK (tick),
        .BTN_PAGE (btn), .LED (led), .SA (sa)
    );

    seg7_scan_display #(
        .SCAN_DIV (SCAN_DIV), .DB_CYCLES (DB_CYCLES), .LZ_BLANK (1'b0)
    ) dut_nolz (
        .CLK (clk), .RESET (rst), .DIGITS (digits), .TICK (tick),
        .BTN_PAGE (btn), .LED (led_nolz), .SA (sa_nolz)
    );

    // ------------------------------------------------------------------
    // Reference model: time-indexed description of the display
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] sa;
        logic [7:0] led;
        logic [7:0] led_nolz;
    } exp_t;

    exp_t expq[$];

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    int         m_c;                 // index of the cycle about to be displayed since reset release
    logic [3:0] m_snap [6];          // H10,H1,M10,M1,S10,S1 left to right
    bit         m_page, m_shown, m_blink, m_level;
    bit         m_s1, m_s2;
    bit         m_hist[$];

    function automatic exp_t model_expect(int cc);
        exp_t e;
        int pos, col;
        logic [3:0] d;
        logic [7:0] s;
        e.sa = 4'b0000; e.led = 8'h00; e.led_nolz = 8'h00;
        if (cc % SCAN_DIV != 0) begin
            pos = (cc / SCAN_DIV) % 4;   // 0 = rightmost digit
            col = 3 - pos;               // 0 = leftmost digit
            d = m_snap[(m_shown ? 2 : 0) + col];
            s = seg_tab[d];
            if (pos == 2 && m_blink) s = s | 8'h80;
            e.sa = 4'(1 << pos);
            e.led_nolz = s;
            e.led = (!m_shown && col == 0 && d == 4'd0) ? (s & 8'h80) : s;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit sample, all_differ;
        if (rst) begin
            m_c = 0; m_page = 0; m_shown = 0; m_blink = 0; m_level = 0;
            m_s1 = 0; m_s2 = 0;
            m_hist.delete();
            for (int i = 0; i < 6; i++) m_snap[i] = 4'h0;
        end else begin
            if (m_c == 0 || m_c % FRAME == FRAME - 1) begin
                for (int i = 0; i < 6; i++) m_snap[i] = digits[23 - 4*i -: 4];
                m_shown = m_page;
            end
            if (tick) m_blink = !m_blink;
            sample = m_s2; m_s2 = m_s1; m_s1 = btn;
            m_hist.push_back(sample);
            if (m_hist.size() > DB_CYCLES) void'(m_hist.pop_front());
            all_differ = (m_hist.size() == DB_CYCLES);
            foreach (m_hist[i]) if (m_hist[i] == m_level) all_differ = 0;
            if (all_differ) begin
                m_level = !m_level;
                m_hist.delete();
                if (m_level) m_page = !m_page;
            end
            m_c++;
        end
        expq.push_back(model_expect(m_c));
    end

    // Monitor: one expected entry per displayed cycle
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (sa !== e.sa || led !== e.led || sa_nolz !== e.sa || led_nolz !== e.led_nolz) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL scoreboard t=%0t: SA=%b LED=%h SA_nolz=%b LED_nolz=%h, wanted SA=%b LED=%h LED_nolz=%h",
                             $time, sa, led, sa_nolz, led_nolz, e.sa, e.led, e.led_nolz);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, wanted %h", name, got, want);
        end
    endtask

    task automatic expect_at(input logic [3:0] want_sa, input logic [7:0] want_led,
                             input bit nolz, input string name);
        bit found = 0;
        logic [7:0] got;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(negedge clk);
            if (sa == want_sa) found = 1;
        end
        got = nolz ? led_nolz : led;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: SA=%b never seen (last SA=%b)", name, want_sa, sa);
        end else if (got !== want_led) begin
            errors++;
            $display("FAIL %s: LED=%h, wanted %h", name, got, want_led);
        end
    endtask

    task automatic wait_frame_start(input string name);
        logic [3:0] prev;
        bit found = 0;
        prev = sa;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            @(negedge clk);
            if (prev == 4'b0000 && sa == 4'b0001) found = 1;
            prev = sa;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: frame start not seen", name);
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; digits = 24'h123456; tick = 1'b0; btn = 1'b0;
        cyc(3);
        @(negedge clk);
        check_now("reset_out", {sa, led}, 12'h000);
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check_now("blank_after_release", {sa, led}, 12'h000);
        @(negedge clk);
        check_now("first_digit", {sa, led}, {4'b0001, 8'h66});
        expect_at(4'b0010, 8'h4F, 0, "p0_m10");
        expect_at(4'b0100, 8'h5B, 0, "p0_h1");
        expect_at(4'b1000, 8'h06, 0, "p0_h10");

        // Short press must not toggle the page
        cyc(1);
        btn = 1'b1; cyc(5); btn = 1'b0;
        cyc(3 * FRAME);
        wait_frame_start("short_press");
        check_now("short_press_ignored", {sa, led}, {4'b0001, 8'h66});

        // Long press, held: exactly one toggle
        cyc(1);
        btn = 1'b1; cyc(20 + 2 * FRAME);
        wait_frame_start("long_press");
        check_now("page1_s1", {sa, led}, {4'b0001, 8'h7D});
        expect_at(4'b0010, 8'h6D, 0, "page1_s10");
        expect_at(4'b0100, 8'h66, 0, "page1_m1");
        expect_at(4'b1000, 8'h4F, 0, "page1_m10");
        cyc(3 * FRAME);
        wait_frame_start("held_press");
        check_now("held_toggles_once", {sa, led}, {4'b0001, 8'h7D});
        cyc(1);
        btn = 1'b0; cyc(20);
        btn = 1'b1; cyc(20);
        btn = 1'b0; cyc(20);

        // Leading-zero blanking, back on page 0
        digits = 24'h050000;
        wait_frame_start("lz_f1");
        wait_frame_start("lz_f2");
        expect_at(4'b0100, 8'h6D, 0, "lz_h1");
        expect_at(4'b1000, 8'h00, 0, "lz_h10_blank");
        expect_at(4'b1000, 8'h3F, 1, "nolz_h10_zero");

        // Colon blink
        cyc(1);
        tick_pulse();
        expect_at(4'b0100, 8'hED, 0, "colon_on");
        expect_at(4'b0001, 8'h3F, 0, "colon_not_d0");
        expect_at(4'b1000, 8'h00, 0, "colon_not_d3");
        cyc(1);
        tick_pulse();
        expect_at(4'b0100, 8'h6D, 0, "colon_off");

        // Mid-frame change must not tear the current frame
        cyc(1);
        digits = 24'h123456;
        wait_frame_start("tear_f1");
        wait_frame_start("tear_f2");
        expect_at(4'b0010, 8'h4F, 0, "tear_m10");
        digits = 24'h1A3456;
        expect_at(4'b0100, 8'h5B, 0, "no_tear_h1");
        expect_at(4'b1000, 8'h06, 0, "no_tear_h10");
        expect_at(4'b0100, 8'h00, 0, "invalid_nibble");

        // Randomised run against the scoreboard, including mid-frame resets
        cyc(1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(9) == 0) digits = $urandom();
            tick = ($urandom_range(7) == 0);
            if ($urandom_range(11) == 0) btn = !btn;
            rst = ($urandom_range(299) == 0) || (i == 1001);
            cyc(1);
        end
        rst = 1'b0; tick = 1'b0; btn = 1'b0;
        cyc(FRAME);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
